// File: rtl/led_pkg.sv
// led_pkg: constants, types and small helpers shared by the LED panel pixel blocks.
package led_pkg;

    localparam int RAMP_DIAG = 0;
    localparam int RAMP_ROW  = 1;
    localparam int RAMP_COL  = 2;

    localparam logic [2:0] CH_R = 3'b001;
    localparam logic [2:0] CH_G = 3'b010;
    localparam logic [2:0] CH_B = 3'b100;

    localparam int INT_BITS = 5;

    typedef logic [INT_BITS-1:0] int_t;

    typedef struct packed {
        logic [2:0] solid;
        logic [2:0] grad;
        int_t       gdist;
    } sector_t;

    // The gradient channel wins over a solid channel; channels that are neither stay dark.
    function automatic int_t chan_dist(input logic is_solid, input logic is_grad, input int_t gdist);
        if (is_grad) begin
            return gdist;
        end else if (is_solid) begin
            return '1;
        end
        return '0;
    endfunction

endpackage

// File: rtl/hue_sector_decode.sv
// hue_sector_decode: maps the 8-bit hue to solid/gradient channel masks and the
// gradient distance for the current sector.
module hue_sector_decode
    import led_pkg::*;
(
    input  logic [7:0] i_hue,
    output sector_t    o_dec
);

    int_t w_frac;
    int_t w_frac_inv;

    assign w_frac     = i_hue[4:0];
    assign w_frac_inv = ~i_hue[4:0];

    always_comb begin
        o_dec = '0;
        case (i_hue[7:5])
            3'd0: begin o_dec.solid = 3'b000;      o_dec.grad = CH_R; o_dec.gdist = w_frac;     end
            3'd1: begin o_dec.solid = CH_R;        o_dec.grad = CH_G; o_dec.gdist = w_frac;     end
            3'd2: begin o_dec.solid = CH_G;        o_dec.grad = CH_R; o_dec.gdist = w_frac_inv; end
            3'd3: begin o_dec.solid = CH_G;        o_dec.grad = CH_B; o_dec.gdist = w_frac;     end
            3'd4: begin o_dec.solid = CH_G | CH_B; o_dec.grad = CH_R; o_dec.gdist = w_frac;     end
            3'd5: begin o_dec.solid = CH_R | CH_B; o_dec.grad = CH_G; o_dec.gdist = w_frac_inv; end
            3'd6: begin o_dec.solid = CH_B;        o_dec.grad = CH_R; o_dec.gdist = w_frac_inv; end
            default: begin o_dec.solid = 3'b000;   o_dec.grad = CH_B; o_dec.gdist = w_frac_inv; end
        endcase
    end

endmodule

// File: rtl/stripe_painter.sv
// stripe_painter: three-stage hue/stripe pixel colouriser between the panel scanner and PWM.
// The diagonal/row/column brightness ramp is built only when STRIPE_PAINTER_DIM_EN is defined.
module stripe_painter
    import led_pkg::*;
#(
    parameter int FRAME_BITS   = 16,
    parameter int COORD_BITS   = 6,
    parameter int COLOR_BITS   = 8,
    parameter int STRIPE_LOG2  = 2,
    parameter int STRIPE_WIDTH = 1,
    parameter int RAMP_MODE    = 0,
    parameter int HUE_SHIFT    = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [FRAME_BITS-1:0]   frame,
    input  logic                    frame_start,
    input  logic                    in_valid,
    input  logic [COORD_BITS-1:0]   x,
    input  logic [COORD_BITS-1:0]   y,
    output logic                    out_valid,
    output logic [3*COLOR_BITS-1:0] rgb
);

    localparam logic [COORD_BITS-1:0] STRIPE_MASK = COORD_BITS'((1 << STRIPE_LOG2) - 1);
    localparam logic [COORD_BITS:0]   STRIPE_W    = (COORD_BITS+1)'(STRIPE_WIDTH);

    logic [7:0] r_hue_q;
    sector_t    w_dec;
    logic       w_lit;
    logic       w_unused;

    logic       r_s1_valid;
    sector_t    r_s1_dec;
    logic       r_s1_lit;

    logic [2:0][INT_BITS-1:0] w_sub;
    logic                     r_s2_valid;
    logic [2:0][INT_BITS-1:0] r_s2_int;
    logic                     r_s2_lit;

    logic [2:0][COLOR_BITS-1:0] w_exp;
    logic                       r_out_valid;
    logic [3*COLOR_BITS-1:0]    r_rgb;

    // Hue only changes on frame_start, so colour is stable for a whole frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hue_q <= '0;
        end else if (frame_start) begin
            r_hue_q <= frame[HUE_SHIFT +: 8];
        end
    end

    hue_sector_decode u_hue_sector_decode (
        .i_hue (r_hue_q),
        .o_dec (w_dec)
    );

    assign w_lit = {1'b0, x & STRIPE_MASK} < STRIPE_W;

`ifdef STRIPE_PAINTER_DIM_EN
    localparam int CW = (COORD_BITS > 6) ? COORD_BITS : 6;

    logic [5:0]    r_off_q;
    logic [CW-1:0] w_xe;
    logic [CW-1:0] w_ye;
    logic [CW-1:0] w_sum;
    logic [5:0]    w_r;
    logic [5:0]    r_s1_r;
    int_t          w_dim;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_off_q <= '0;
        end else if (frame_start) begin
            r_off_q <= frame[5:0];
        end
    end

    assign w_xe = CW'(x);
    assign w_ye = CW'(y);

    always_comb begin
        case (RAMP_MODE)
            RAMP_ROW: w_sum = w_ye;
            RAMP_COL: w_sum = w_xe;
            default:  w_sum = w_xe + w_ye;
        endcase
    end

    assign w_r = w_sum[5:0] + r_off_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_r <= '0;
        end else begin
            r_s1_r <= w_r;
        end
    end

    // Triangular ramp: rises over the first half of the 64-step period, falls over the second.
    assign w_dim    = r_s1_r[5] ? ~r_s1_r[4:0] : r_s1_r[4:0];
    assign w_unused = &{1'b0, frame, w_sum};
`else
    assign w_unused = &{1'b0, frame, y};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_dec   <= '0;
            r_s1_lit   <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_dec   <= w_dec;
            r_s1_lit   <= w_lit;
        end
    end

    always_comb begin
        w_sub = '0;
        for (int c = 0; c < 3; c++) begin
`ifdef STRIPE_PAINTER_DIM_EN
            if (chan_dist(r_s1_dec.solid[c], r_s1_dec.grad[c], r_s1_dec.gdist) < w_dim) begin
                w_sub[c] = '0;
            end else begin
                w_sub[c] = chan_dist(r_s1_dec.solid[c], r_s1_dec.grad[c], r_s1_dec.gdist) - w_dim;
            end
`else
            w_sub[c] = chan_dist(r_s1_dec.solid[c], r_s1_dec.grad[c], r_s1_dec.gdist);
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s2_valid <= 1'b0;
            r_s2_int   <= '0;
            r_s2_lit   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_int   <= w_sub;
            r_s2_lit   <= r_s1_lit;
        end
    end

    // Widen each 5-bit intensity by repeating it MSB-first until the channel is full.
    always_comb begin
        w_exp = '0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < COLOR_BITS; k++) begin
                w_exp[c][COLOR_BITS-1-k] = r_s2_int[c][INT_BITS-1-(k % INT_BITS)];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_out_valid <= r_s2_valid;
            r_rgb       <= r_s2_lit ? w_exp : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign rgb       = r_rgb;

endmodule
